// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   DBITS, DMEMADDRBITS, DMEMWORDBITS : bus, decode and word-offset widths
//                                       (the CPU top uses the same values)
//   MEM_ADDR_W                        : dmem word-index width
//   BUS_ERR_DATA                      : read data returned for out-of-range reads
//   arb_mode_e                        : arbitration mode decoded from the starvation count
//   in_range()                        : true when an address decodes into dmem
package dmem_port_arbiter_pkg;

  localparam int DBITS        = 32;
  localparam int DMEMADDRBITS = 16;
  localparam int DMEMWORDBITS = 2;
  localparam int MEM_ADDR_W   = DMEMADDRBITS - DMEMWORDBITS;

  localparam logic [DBITS-1:0] BUS_ERR_DATA = 32'hDEAD_DEAD;

  typedef enum logic {
    CPU_PRI   = 1'b0,  // CPU wins conflicts
    AUX_FORCE = 1'b1   // aux has waited long enough and wins conflicts
  } arb_mode_e;

  // Any set bit above the decoded range means the access misses dmem.
  function automatic logic in_range(input logic [DBITS-1:0] addr);
    return addr[DBITS-1:DMEMADDRBITS] == '0;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// One requester's view of the arbitrated data-memory port.
//   req, we, addr, wdata : request from the requester (hold until gnt)
//   gnt                  : request accepted this cycle
//   rvalid, rdata        : read completion, one cycle after a read grant
// master = requester side, slave = arbiter side.
interface dmem_port_arbiter_if;
  import dmem_port_arbiter_pkg::*;

  logic             req;
  logic             we;
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic             gnt;
  logic             rvalid;
  logic [DBITS-1:0] rdata;

  modport master (output req, we, addr, wdata, input  gnt, rvalid, rdata);
  modport slave  (input  req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/dmem_port_arbiter_starve_counter.sv
// Saturating counter with synchronous clear, used to count how many cycles the
// aux port has been refused.
//   clk, RESET_N : clock, asynchronous active-low reset
//   clr          : return to zero at the next edge (has priority over inc)
//   inc          : count up at the next edge, holding at LIMIT
//   cnt          : current count
module starve_counter #(
  parameter int LIMIT = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

  if (LIMIT >= (2 ** WIDTH)) begin : g_bad_width
    $error("starve_counter: LIMIT does not fit in WIDTH bits");
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT_W)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port dmem between the CPU M stage (port 0) and the aux
// loader/debug port (port 1). The CPU normally wins; after STARVELIMIT refused
// aux cycles the aux port wins the next conflict. Reads complete one cycle
// after grant; out-of-range reads return BUS_ERR_DATA and pulse oor, and
// out-of-range writes are accepted but never reach dmem.
//   clk, RESET_N : clock, asynchronous active-low reset
//   p0, p1       : requester ports (CPU, aux)
//   oor          : pulses with rvalid when the completed read was out of range
//   mem_en       : dmem access strobe
//   mem_we       : dmem write enable
//   mem_addr     : dmem word index
//   mem_wdata    : dmem write data
//   mem_rdata    : dmem read data, valid the cycle after a read strobe
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int STARVELIMIT = 4,
  parameter int WAITBITS    = 3
) (
  input  logic                  clk,
  input  logic                  RESET_N,
  dmem_port_arbiter_if.slave    p0,
  dmem_port_arbiter_if.slave    p1,
  output logic                  oor,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DBITS-1:0]      mem_wdata,
  input  logic [DBITS-1:0]      mem_rdata
);

  logic [WAITBITS-1:0] wait_cnt;
  arb_mode_e           mode;
  logic                gnt0, gnt1, any_gnt;
  logic                sel_we, inr;
  logic [DBITS-1:0]    sel_addr, sel_wdata;
  logic                rd_pend0, rd_pend1, oor_pend;
  logic [DBITS-1:0]    rd_data;
  logic                unused_addr_bits;

  starve_counter #(
    .LIMIT (STARVELIMIT),
    .WIDTH (WAITBITS)
  ) u_starve (
    .clk     (clk),
    .RESET_N (RESET_N),
    .clr     (gnt1 | ~p1.req),  // a grant or a withdrawn request forfeits credit
    .inc     (p1.req & ~gnt1),
    .cnt     (wait_cnt)
  );

  // NOTE: every signal assigned in this block gets a value before any branch,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    mode = (wait_cnt == WAITBITS'(STARVELIMIT)) ? AUX_FORCE : CPU_PRI;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    // Grants are combinational, so they are gated by reset to keep every
    // output low while reset is held.
    if (RESET_N) begin
      if (mode == AUX_FORCE) begin
        gnt1 = p1.req;
        gnt0 = p0.req & ~p1.req;
      end else begin
        gnt0 = p0.req;
        gnt1 = p1.req & ~p0.req;
      end
    end

    any_gnt   = gnt0 | gnt1;
    sel_we    = gnt1 ? p1.we    : p0.we;
    sel_addr  = gnt1 ? p1.addr  : p0.addr;
    sel_wdata = gnt1 ? p1.wdata : p0.wdata;
    inr       = in_range(sel_addr);

    mem_en    = any_gnt & inr;
    mem_we    = mem_en & sel_we;
    mem_addr  = any_gnt ? sel_addr[DMEMADDRBITS-1:DMEMWORDBITS] : '0;
    mem_wdata = any_gnt ? sel_wdata : '0;
  end

  // Byte offset is dropped when forming the word index.
  assign unused_addr_bits = ^sel_addr[DMEMWORDBITS-1:0];

  // Completion tracking: one read is in flight at most, so a single oor flag
  // covers both ports.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_pend0 <= 1'b0;
      rd_pend1 <= 1'b0;
      oor_pend <= 1'b0;
    end else begin
      rd_pend0 <= gnt0 & ~p0.we;
      rd_pend1 <= gnt1 & ~p1.we;
      oor_pend <= any_gnt & ~sel_we & ~inr;
    end
  end

  assign rd_data   = oor_pend ? BUS_ERR_DATA : mem_rdata;
  assign p0.gnt    = gnt0;
  assign p1.gnt    = gnt1;
  assign p0.rvalid = rd_pend0;
  assign p1.rvalid = rd_pend1;
  assign p0.rdata  = rd_pend0 ? rd_data : '0;
  assign p1.rdata  = rd_pend1 ? rd_data : '0;
  assign oor       = oor_pend;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios followed by
// randomized traffic, with a reference model of the arbitration rules and a
// scoreboard of expected read completions.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int LIMIT = 4;
  localparam int WORDS = 2 ** MEM_ADDR_W;

  logic                  clk = 1'b0;
  logic                  RESET_N;
  logic                  oor, mem_en, mem_we;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [DBITS-1:0]      mem_wdata;
  logic [DBITS-1:0]      mem_rdata = '0;

  dmem_port_arbiter_if p0_if ();
  dmem_port_arbiter_if p1_if ();

  dmem_port_arbiter #(.STARVELIMIT(LIMIT), .WAITBITS(3)) dut (
    .clk       (clk),
    .RESET_N   (RESET_N),
    .p0        (p0_if.slave),
    .p1        (p1_if.slave),
    .oor       (oor),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // dmem array the arbiter drives
  logic [DBITS-1:0] dmem [0:WORDS-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) dmem[mem_addr] <= mem_wdata;
      else        mem_rdata      <= dmem[mem_addr];
    end
  end

  // Reference model state
  logic [DBITS-1:0] mmodel [0:WORDS-1];
  int               wait_m;
  bit               last_g0, last_g1;
  int               cyc = 0;

  typedef struct {
    int               port;
    logic [DBITS-1:0] data;
    bit               oor;
    int               due;
  } exp_t;
  exp_t sb[$];

  int vectors    = 0;
  int miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic set_port(input int port, input bit req, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      p0_if.req = req; p0_if.we = we; p0_if.addr = addr; p0_if.wdata = wdata;
    end else begin
      p1_if.req = req; p1_if.we = we; p1_if.addr = addr; p1_if.wdata = wdata;
    end
  endtask

  // One clock: at the falling edge compare grant and strobes with the model,
  // queue the expected read completion, then advance to just after the edge.
  task automatic cycle();
    bit r0, r1, w, g0, g1, aux_turn, inr, any;
    logic [31:0] a, d;
    @(negedge clk);
    r0 = p0_if.req;
    r1 = p1_if.req;
    aux_turn = (wait_m == LIMIT);
    g0 = r0 && !(r1 && aux_turn);
    g1 = r1 && !(r0 && !aux_turn);
    any = g0 || g1;
    check("gnt0", p0_if.gnt, g0);
    check("gnt1", p1_if.gnt, g1);
    if (g1) begin a = p1_if.addr; d = p1_if.wdata; w = p1_if.we; end
    else    begin a = p0_if.addr; d = p0_if.wdata; w = p0_if.we; end
    inr = (a < 32'h0001_0000);
    check("mem_en", mem_en, any && inr);
    check("mem_we", mem_we, any && inr && w);
    if (any && inr) check("mem_addr", 32'(mem_addr), a >> 2);
    if (any && inr && w) check("mem_wdata", mem_wdata, d);
    if (any && !w)
      sb.push_back('{port: (g1 ? 1 : 0), data: (inr ? mmodel[a >> 2] : 32'hDEAD_DEAD),
                     oor: !inr, due: cyc + 1});
    if (any && inr && w) mmodel[a >> 2] = d;
    if (g1)      wait_m = 0;
    else if (r1) wait_m = (wait_m < LIMIT) ? wait_m + 1 : LIMIT;
    else         wait_m = 0;
    last_g0 = g0;
    last_g1 = g1;
    @(posedge clk);
    #1;
  endtask

  // Completion monitor
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   any_v;
    if (RESET_N) begin
      any_v = p0_if.rvalid | p1_if.rvalid;
      if (p0_if.rvalid && p1_if.rvalid) check("rvalid_both", 32'd1, 32'd0);
      if (!any_v) begin
        if (oor) check("oor_without_rvalid", oor, 0);
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          check("rvalid_at_due", any_v, 1);
          void'(sb.pop_front());
        end
      end else if (sb.size() == 0) begin
        check("rvalid_unexpected", any_v, 0);
      end else begin
        e = sb.pop_front();
        check("rvalid_port", p1_if.rvalid, e.port);
        check("rvalid_cycle", cyc, e.due);
        check("rdata", p1_if.rvalid ? p1_if.rdata : p0_if.rdata, e.data);
        check("oor", oor, e.oor);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt0"}, p0_if.gnt, 0);
    check({tag, "_gnt1"}, p1_if.gnt, 0);
    check({tag, "_rvalid0"}, p0_if.rvalid, 0);
    check({tag, "_rvalid1"}, p1_if.rvalid, 0);
    check({tag, "_rdata0"}, p0_if.rdata, 0);
    check({tag, "_rdata1"}, p1_if.rdata, 0);
    check({tag, "_oor"}, oor, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h0001_0000 | ($urandom() & 32'h00FF_FFFC);
    if (r == 1) return 32'hFFFF_F000;
    if (r == 2) return 32'h0000_FFFC;
    return (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic rand_req(input int port);
    set_port(port, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
             rand_addr(), $urandom());
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      dmem[i]   = 32'hC0DE_0000 ^ 32'(i);
      mmodel[i] = 32'hC0DE_0000 ^ 32'(i);
    end
    dmem[16]   = 32'h0000_1234;
    mmodel[16] = 32'h0000_1234;
    wait_m = 0;

    // Reset with requests pending: everything stays low
    RESET_N = 1'b0;
    set_port(0, 1, 0, 32'h40, 0);
    set_port(1, 1, 1, 32'h44, 32'h1);
    #1;
    check_all_zero("reset");
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    RESET_N = 1'b1;

    // 1: single CPU read of word 0x10
    set_port(0, 1, 0, 32'h40, 0);
    cycle();
    set_port(0, 0, 0, 0, 0);
    cycle();

    // 2: continuous conflict, aux every 5th cycle
    set_port(0, 1, 0, 32'h8, 0);
    set_port(1, 1, 0, 32'hC, 0);
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("conflict_gnt1_slot", last_g1, (k % 5) == 4);
    end
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    cycle();

    // 3: out-of-range aux read
    set_port(1, 1, 0, 32'h0001_0000, 0);
    cycle();
    set_port(1, 0, 0, 0, 0);
    cycle();

    // 4: out-of-range write dropped, then read the aliased in-range word
    set_port(0, 1, 1, 32'hFFFF_F000, 32'h5555_AAAA);
    cycle();
    set_port(0, 1, 0, 32'h0000_F000, 0);
    cycle();
    set_port(0, 0, 0, 0, 0);
    cycle();

    // 5: CPU read then aux read on consecutive cycles
    set_port(0, 1, 0, 32'h0, 0);
    cycle();
    set_port(0, 0, 0, 0, 0);
    set_port(1, 1, 0, 32'h4, 0);
    cycle();
    set_port(1, 0, 0, 0, 0);
    cycle();
    cycle();

    // 6: reset in the cycle after a read grant, with starvation credit built up
    set_port(0, 1, 0, 32'h20, 0);
    set_port(1, 1, 0, 32'h24, 0);
    cycle();
    cycle();
    RESET_N = 1'b0;
    sb.delete();
    wait_m = 0;
    #1;
    check_all_zero("reset_mid_read");
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    RESET_N = 1'b1;
    cycle();
    set_port(0, 1, 1, 32'h30, 32'h0BAD_F00D);
    set_port(1, 1, 1, 32'h34, 32'h0DEC_AF00);
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("post_reset_gnt1_slot", last_g1, k == 4);
    end
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    cycle();

    // Randomized traffic; aux occasionally withdraws to exercise credit loss
    for (int n = 0; n < 1500; n++) begin
      if (!p0_if.req || last_g0) rand_req(0);
      if (!p1_if.req || last_g1) rand_req(1);
      else if ($urandom_range(0, 19) == 0) p1_if.req = 1'b0;
      cycle();
    end
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    repeat (3) cycle();
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
